multi_clkgen: RTL and testbench
===============================

MULTI_CLKGEN -- requirements
Module: multi_clkgen

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent output clock channels, 1..8.
REQ-002 Parameter CNT_W, default 8: width of the period/high-time counters and configuration fields.
REQ-003 clock  input  1  single system clock; all logic rises on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 ch_en  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-006 cfg_we  input  1  configuration write strobe, one-cycle pulse per write.
REQ-007 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index for cfg_we.
REQ-008 cfg_period  input  CNT_W  period in clock cycles (PER).
REQ-009 cfg_high  input  CNT_W  high time in clock cycles (HI).
REQ-010 sync_restart  input  1  one-cycle pulse; phase-aligns all enabled channels.
REQ-011 clk_out  output  NUM_CH  generated clocks, registered.
REQ-012 cfg_pending  output  NUM_CH  shadow config written but not yet applied.

Function
REQ-013 Each channel SHALL hold an active (PER, HI) pair, a shadow pair, a pending flag and a counter cnt of CNT_W bits.
REQ-014 An enabled channel SHALL count cnt 0..PER-1, wrapping to 0 on the cycle after cnt == PER-1.
REQ-015 clk_out[i] SHALL be registered as (cnt < HI), giving a period of PER cycles and a duty of HI/PER; an enabled channel's first high cycle appears one cycle after ch_en rises.
REQ-016 PER < 2 SHALL force clk_out[i] low with cnt held at 0; HI = 0 SHALL give constant low; HI >= PER SHALL give constant high.
REQ-017 cfg_we with cfg_ch < NUM_CH SHALL load the shadow pair and set cfg_pending[cfg_ch] on the next edge; cfg_ch >= NUM_CH SHALL be ignored.
REQ-018 A pending shadow SHALL be copied to active only at a period boundary (cnt == PER-1), on sync_restart, or while the channel is disabled; cfg_pending clears on the same edge, so no truncated or stretched period is ever emitted.
REQ-019 cfg_we to a channel on its boundary cycle SHALL apply the previously pending shadow (if any), store the new shadow, and leave cfg_pending set.
REQ-020 ch_en[i] low SHALL hold cnt at 0 and drive clk_out[i] low on the next edge; re-enabling restarts from cnt = 0.
REQ-021 sync_restart SHALL reset cnt to 0 on all enabled channels and apply all pending shadows in the same edge; it takes priority over normal wrap.
REQ-022 Channels SHALL be fully independent apart from sync_restart; no combinational path from any input to clk_out.

Reset
REQ-023 reset SHALL set every channel to active PER = 2, HI = 1, shadow PER = 2, HI = 1, cnt = 0, cfg_pending = 0, clk_out = 0.
REQ-024 reset SHALL take priority over cfg_we, sync_restart and ch_en; reset asserted mid-period aborts the period and clk_out is low on the next edge.
REQ-025 After reset deasserts with ch_en high, clk_out SHALL toggle at clock/2 starting high one cycle later.

Configuration
REQ-026 Macro MULTI_CLKGEN_TICK_EN SHALL add output tick, width NUM_CH, registered, high for exactly one cycle coincident with every clk_out rising edge (cycle where cnt == 0 and HI > 0 and PER >= 2).
REQ-027 Without MULTI_CLKGEN_TICK_EN the tick port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, ch_en = all ones -> all clk_out toggle every cycle, 1,0,1,0..., cfg_pending = 0.
REQ-029 Write ch0 PER = 10, HI = 3 mid-period -> cfg_pending[0] = 1 until boundary, then 3 high / 7 low repeating; no intermediate short period.
REQ-030 Write ch1 PER = 5, HI = 0, then HI = 5, then PER = 1 -> constant low, constant high, constant low respectively, each after its boundary.
REQ-031 ch0 PER = 4, ch1 PER = 6, free-running, pulse sync_restart -> both clk_out rise together the next cycle, pending writes applied at that edge.
REQ-032 Write to cfg_ch = NUM_CH (NUM_CH = 3, cfg_ch = 3) -> no state change, cfg_pending unchanged; cfg_we on ch2 boundary cycle -> old shadow applied, new one pending.
REQ-033 With MULTI_CLKGEN_TICK_EN, PER = 8, HI = 2 -> tick one cycle every 8, aligned with clk_out rise; assert reset for 1 cycle mid-high -> clk_out and tick low next edge.

Source files
------------

// File: rtl/multi_clkgen.sv
// -----------------------------------------------------------------------------
// multi_clkgen: NUM_CH independent, programmable, registered clock generators.
//
// Each channel counts 0..PER-1 and outputs (cnt < HI). New (PER, HI) settings
// go into a shadow pair first and are applied only at a period boundary,
// on sync_restart, or while the channel is disabled, so periods are never
// truncated or stretched.
//
// Ports:
//   clock        system clock, all state on its rising edge
//   reset        synchronous active-high reset
//   ch_en        per-channel run enable (level)
//   cfg_we       configuration write strobe
//   cfg_ch       channel index for cfg_we (out-of-range writes are dropped)
//   cfg_period   period in clock cycles (PER)
//   cfg_high     high time in clock cycles (HI)
//   sync_restart phase-aligns all enabled channels, applies pending shadows
//   clk_out      generated clocks (registered)
//   cfg_pending  shadow written but not yet active
//   tick         (only with MULTI_CLKGEN_TICK_EN) one-cycle pulse on the
//                first cycle of each period (cnt == 0, HI > 0, PER >= 2)
//
// Build option: define MULTI_CLKGEN_TICK_EN to add the tick output.
// -----------------------------------------------------------------------------
module multi_clkgen #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cfg_pending
`ifdef MULTI_CLKGEN_TICK_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
        logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_hi_q, sh_hi_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d, clk_q, clk_d;
        logic             wr, boundary, apply, run_ok;
        logic [CNT_W-1:0] eff_per, eff_hi, eff_cnt;
`ifdef MULTI_CLKGEN_TICK_EN
        logic             tick_q, tick_d;
`endif

        always_comb begin
            wr       = cfg_we && (cfg_ch == CH_W'(i));
            // PER < 2 keeps cnt at 0, so treat every cycle as a boundary
            boundary = (per_q < CNT_W'(2)) || (cnt_q == per_q - CNT_W'(1));
            apply    = pend_q && (!ch_en[i] || sync_restart || boundary);

            // sync_restart restarts the period on this very edge, using the
            // shadow values it applies; otherwise the active pair governs
            eff_per = (sync_restart && pend_q) ? sh_per_q : per_q;
            eff_hi  = (sync_restart && pend_q) ? sh_hi_q : hi_q;
            eff_cnt = sync_restart ? '0 : cnt_q;
            run_ok  = ch_en[i] && (eff_per >= CNT_W'(2));

            per_d    = apply ? sh_per_q : per_q;
            hi_d     = apply ? sh_hi_q : hi_q;
            sh_per_d = wr ? cfg_period : sh_per_q;
            sh_hi_d  = wr ? cfg_high : sh_hi_q;
            // a write on the apply edge leaves the new shadow pending
            pend_d   = wr || (pend_q && !apply);

            cnt_d = '0;
            clk_d = 1'b0;
            if (run_ok) begin
                clk_d = eff_cnt < eff_hi;
                if (eff_cnt != eff_per - CNT_W'(1)) begin
                    cnt_d = eff_cnt + CNT_W'(1);
                end
            end
`ifdef MULTI_CLKGEN_TICK_EN
            tick_d = run_ok && (eff_cnt == '0) && (eff_hi != '0);
`endif
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                per_q    <= CNT_W'(2);
                hi_q     <= CNT_W'(1);
                sh_per_q <= CNT_W'(2);
                sh_hi_q  <= CNT_W'(1);
                cnt_q    <= '0;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
`ifdef MULTI_CLKGEN_TICK_EN
                tick_q   <= 1'b0;
`endif
            end else begin
                per_q    <= per_d;
                hi_q     <= hi_d;
                sh_per_q <= sh_per_d;
                sh_hi_q  <= sh_hi_d;
                cnt_q    <= cnt_d;
                pend_q   <= pend_d;
                clk_q    <= clk_d;
`ifdef MULTI_CLKGEN_TICK_EN
                tick_q   <= tick_d;
`endif
            end
        end

        assign clk_out[i]     = clk_q;
        assign cfg_pending[i] = pend_q;
`ifdef MULTI_CLKGEN_TICK_EN
        assign tick[i]        = tick_q;
`endif
    end

endmodule

// File: tb/tb_multi_clkgen.sv
// -----------------------------------------------------------------------------
// tb_multi_clkgen: directed self-checking bench for multi_clkgen (NUM_CH = 3,
// CNT_W = 8). Expected waveforms are hand-derived bit strings, first
// observation in the MSB. Outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_multi_clkgen;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic              sync_restart;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] cfg_pending;
`ifdef MULTI_CLKGEN_TICK_EN
    logic [NUM_CH-1:0] tick;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    multi_clkgen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_en       (ch_en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .sync_restart(sync_restart),
        .clk_out     (clk_out),
        .cfg_pending (cfg_pending)
`ifdef MULTI_CLKGEN_TICK_EN
        ,
        .tick        (tick)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] ch, input int per, input int hi);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = CNT_W'(per);
        cfg_high   = CNT_W'(hi);
    endtask

    task automatic do_reset(input logic [NUM_CH-1:0] en);
        reset        = 1'b1;
        ch_en        = en;
        cfg_we       = 1'b0;
        sync_restart = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Reset wins over cfg_we, sync_restart, ch_en; then clock/2 on all channels.
    task automatic test_reset();
        logic [NUM_CH-1:0] exp;
        reset = 1'b1;
        ch_en = 3'b111;
        set_wr(2'd0, 5, 2);
        sync_restart = 1'b1;
        step();
        n_vec++;
        if (clk_out !== 3'b000) begin
            $display("FAIL reset_clk got %b want 000", clk_out);
            n_err++;
        end
        n_vec++;
        if (cfg_pending !== 3'b000) begin
            $display("FAIL reset_pend got %b want 000", cfg_pending);
            n_err++;
        end
        reset = 1'b0;
        cfg_we = 1'b0;
        sync_restart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            exp = (k % 2 == 0) ? 3'b111 : 3'b000;
            n_vec++;
            if (clk_out !== exp) begin
                $display("FAIL div2 k=%0d got %b want %b", k, clk_out, exp);
                n_err++;
            end
            n_vec++;
            if (cfg_pending !== 3'b000) begin
                $display("FAIL div2_pend k=%0d got %b want 000", k, cfg_pending);
                n_err++;
            end
        end
    endtask

    // ch0: PER=10/HI=3, then a mid-period write of PER=6/HI=2.
    task automatic test_period();
        logic exp_clk, exp_pend;
        do_reset(3'b001);
        for (int n = 0; n < 24; n++) begin
            // n0..1: default PER=2, n2..11: PER=10, n12..23: PER=6
            if (n == 0) set_wr(2'd0, 10, 3);
            else if (n == 6) set_wr(2'd0, 6, 2);
            else cfg_we = 1'b0;
            step();
            if (n < 2) begin
                exp_clk  = (n == 0);
                exp_pend = (n == 0);
            end else if (n < 12) begin
                exp_clk  = (n - 2) < 3;
                exp_pend = (n >= 6) && (n <= 10);
            end else begin
                exp_clk  = ((n - 12) % 6) < 2;
                exp_pend = 1'b0;
            end
            n_vec++;
            if (clk_out !== {2'b00, exp_clk}) begin
                $display("FAIL period_clk n=%0d got %b want %b", n, clk_out, {2'b00, exp_clk});
                n_err++;
            end
            n_vec++;
            if (cfg_pending !== {2'b00, exp_pend}) begin
                $display("FAIL period_pend n=%0d got %b want %b", n, cfg_pending,
                         {2'b00, exp_pend});
                n_err++;
            end
        end
    endtask

    // ch1: HI=0 -> constant low, HI=PER -> constant high, PER=1 -> forced low.
    task automatic test_levels();
        logic [21:0] e_clk;
        logic [21:0] e_pend;
        e_clk  = 22'b1_000000_1111111111_00000;
        e_pend = 22'b1_0_1111_000000_1111_000000;
        do_reset(3'b010);
        for (int n = 0; n < 22; n++) begin
            if (n == 0) set_wr(2'd1, 5, 0);
            else if (n == 2) set_wr(2'd1, 5, 5);
            else if (n == 12) set_wr(2'd1, 1, 5);
            else cfg_we = 1'b0;
            step();
            n_vec++;
            if (clk_out !== {1'b0, e_clk[21-n], 1'b0}) begin
                $display("FAIL levels_clk n=%0d got %b want %b", n, clk_out,
                         {1'b0, e_clk[21-n], 1'b0});
                n_err++;
            end
            n_vec++;
            if (cfg_pending !== {1'b0, e_pend[21-n], 1'b0}) begin
                $display("FAIL levels_pend n=%0d got %b want %b", n, cfg_pending,
                         {1'b0, e_pend[21-n], 1'b0});
                n_err++;
            end
        end
    endtask

    // ch0 PER=4, ch1 PER=6 free-running; sync_restart at n14 with both pending.
    task automatic test_sync();
        logic [23:0] e0, e1, p0, p1;
        logic [NUM_CH-1:0] exp;
        e0 = 24'b1011_0011_0011_0010_0010_0010;
        e1 = 24'b1010_1110_0011_1010_0000_1000;
        p0 = 24'b1000_0000_0000_0100_0000_0000;
        p1 = 24'b0110_0000_0000_1100_0000_0000;
        do_reset(3'b011);
        for (int n = 0; n < 24; n++) begin
            if (n == 0) set_wr(2'd0, 4, 2);
            else if (n == 1) set_wr(2'd1, 6, 3);
            else if (n == 12) set_wr(2'd1, 6, 1);
            else if (n == 13) set_wr(2'd0, 4, 1);
            else cfg_we = 1'b0;
            sync_restart = (n == 14);
            step();
            exp = {1'b0, e1[23-n], e0[23-n]};
            n_vec++;
            if (clk_out !== exp) begin
                $display("FAIL sync_clk n=%0d got %b want %b", n, clk_out, exp);
                n_err++;
            end
            exp = {1'b0, p1[23-n], p0[23-n]};
            n_vec++;
            if (cfg_pending !== exp) begin
                $display("FAIL sync_pend n=%0d got %b want %b", n, cfg_pending, exp);
                n_err++;
            end
        end
        sync_restart = 1'b0;
    endtask

    // Write to cfg_ch=3 is dropped; write on ch2 boundary applies the old shadow.
    task automatic test_bad_ch();
        logic [20:0] e_clk, e_pend;
        e_clk  = 21'b101010110000111000001;
        e_pend = 21'b0000_1111111_0000000000;
        do_reset(3'b100);
        for (int n = 0; n < 21; n++) begin
            if (n == 0) set_wr(2'd3, 5, 2);
            else if (n == 4) set_wr(2'd2, 6, 2);
            else if (n == 5) set_wr(2'd2, 8, 3);
            else cfg_we = 1'b0;
            step();
            n_vec++;
            if (clk_out !== {e_clk[20-n], 2'b00}) begin
                $display("FAIL badch_clk n=%0d got %b want %b", n, clk_out,
                         {e_clk[20-n], 2'b00});
                n_err++;
            end
            n_vec++;
            if (cfg_pending !== {e_pend[20-n], 2'b00}) begin
                $display("FAIL badch_pend n=%0d got %b want %b", n, cfg_pending,
                         {e_pend[20-n], 2'b00});
                n_err++;
            end
        end
    endtask

    // ch0 PER=4/HI=3: disable mid-high, re-enable restarts, reset mid-high.
    task automatic test_enable_reset();
        logic [13:0] e_clk;
        e_clk = 14'b10110011101010;
        do_reset(3'b001);
        for (int n = 0; n < 14; n++) begin
            if (n == 0) set_wr(2'd0, 4, 3);
            else cfg_we = 1'b0;
            ch_en = (n == 4 || n == 5) ? 3'b000 : 3'b001;
            reset = (n == 11);
            step();
            n_vec++;
            if (clk_out !== {2'b00, e_clk[13-n]}) begin
                $display("FAIL en_clk n=%0d got %b want %b", n, clk_out,
                         {2'b00, e_clk[13-n]});
                n_err++;
            end
            n_vec++;
            if (cfg_pending !== {2'b00, (n == 0)}) begin
                $display("FAIL en_pend n=%0d got %b want %b", n, cfg_pending,
                         {2'b00, (n == 0)});
                n_err++;
            end
        end
        reset = 1'b0;
    endtask

`ifdef MULTI_CLKGEN_TICK_EN
    // ch0 PER=8/HI=2: tick on each period start; reset mid-high clears both.
    task automatic test_tick();
        logic [13:0] e_clk, e_tick;
        e_clk  = 14'b10110000001010;
        e_tick = 14'b10100000001010;
        do_reset(3'b001);
        for (int n = 0; n < 14; n++) begin
            if (n == 0) set_wr(2'd0, 8, 2);
            else cfg_we = 1'b0;
            reset = (n == 11);
            step();
            n_vec++;
            if (clk_out !== {2'b00, e_clk[13-n]}) begin
                $display("FAIL tick_clk n=%0d got %b want %b", n, clk_out,
                         {2'b00, e_clk[13-n]});
                n_err++;
            end
            n_vec++;
            if (tick !== {2'b00, e_tick[13-n]}) begin
                $display("FAIL tick n=%0d got %b want %b", n, tick, {2'b00, e_tick[13-n]});
                n_err++;
            end
        end
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        ch_en        = '0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_period   = '0;
        cfg_high     = '0;
        sync_restart = 1'b0;
        step();
        test_reset();
        test_period();
        test_levels();
        test_sync();
        test_bad_ch();
        test_enable_reset();
`ifdef MULTI_CLKGEN_TICK_EN
        test_tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
